// File: rtl/gemm_issue_ctrl.sv
// Issue controller for the GEMM functional unit: holds one dispatched op, waits for its
// matrix operands, issues it over valid/ready, then pulses writeback on the matching completion.
module gemm_issue_ctrl #(
  parameter int REG_W   = 4,
  parameter int NREGS   = 16,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dispatch_en,
  input  logic [REG_W-1:0] dispatch_rs1,
  input  logic [REG_W-1:0] dispatch_rs2,
  input  logic [REG_W-1:0] dispatch_rs3,
  input  logic [REG_W-1:0] dispatch_rd,
  input  logic [TAG_W-1:0] dispatch_tag,
  output logic             dispatch_ready,
  input  logic [NREGS-1:0] reg_ready,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [REG_W-1:0] issue_rs1,
  output logic [REG_W-1:0] issue_rs2,
  output logic [REG_W-1:0] issue_rs3,
  output logic [REG_W-1:0] issue_rd,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             done_valid,
  input  logic [TAG_W-1:0] done_tag,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  input  logic             flush,
  output logic [1:0]       err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OPS = 3'd1,
    ISSUE    = 3'd2,
    EXEC     = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  localparam logic [7:0] CNT_MAX   = 8'hFF;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t           state, state_nxt;
  logic [REG_W-1:0] rs1_q, rs2_q, rs3_q, rd_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       cnt_q, cnt_nxt;
  logic [1:0]       err_q;
  logic             ops_ready, tag_match, accept, wb_fire;

  // Duplicate indices simply select the same bit, so no special case is needed.
  assign ops_ready = reg_ready[rs1_q] & reg_ready[rs2_q] & reg_ready[rs3_q];
  assign tag_match = done_valid && (done_tag == tag_q);
  assign accept    = (state == IDLE) && dispatch_en && !flush;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    wb_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_OPS;
      end
      WAIT_OPS: begin
        if (flush)          state_nxt = IDLE;
        else if (ops_ready) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (issue_ready) begin
          state_nxt = flush ? DRAIN : EXEC;
          cnt_nxt   = '0;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        if (tag_match) begin
          state_nxt = IDLE;
          wb_fire   = !flush;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_match) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      rd_q  <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (accept) begin
        rs1_q <= dispatch_rs1;
        rs2_q <= dispatch_rs2;
        rs3_q <= dispatch_rs3;
        rd_q  <= dispatch_rd;
        tag_q <= dispatch_tag;
      end
      if (dispatch_en && state != IDLE)                err_q[0] <= 1'b1;
      if (state == EXEC && cnt_nxt == TIMEOUT_C)       err_q[1] <= 1'b1;
    end
  end

  assign dispatch_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign issue_valid    = (state == ISSUE);
  assign issue_rs1      = rs1_q;
  assign issue_rs2      = rs2_q;
  assign issue_rs3      = rs3_q;
  assign issue_rd       = rd_q;
  assign issue_tag      = tag_q;
  assign wb_valid       = wb_fire;
  assign wb_rd          = wb_fire ? rd_q  : '0;
  assign wb_tag         = wb_fire ? tag_q : '0;
  assign err            = err_q;

endmodule

// File: doc/gemm_issue_ctrl.md
Name: gemm_issue_ctrl

Overview:
- Per-unit issue controller for the GEMM functional unit. It sits directly downstream of the GEMM functional-unit status entry.
- Accepts one dispatched GEMM op (sources A/B/C, destination, tag) and waits until all three matrix source registers are ready.
- Issues the op to the GEMM datapath over a valid/ready handshake, then tracks completion and emits a one-cycle writeback pulse.
- Drives the busy flag that the status entry latches.

Parameters:
REG_W, 4, matrix register index width
NREGS, 16, number of matrix registers (2**REG_W)
TAG_W, 5, op tag width
TIMEOUT, 255, EXEC cycles before timeout error flag sets (8-bit counter)

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous reset, active-high (1 = reset)
dispatch_en  in  1  new GEMM op presented
dispatch_rs1/rs2/rs3  in  REG_W each  A, B, C source registers
dispatch_rd  in  REG_W  destination register
dispatch_tag  in  TAG_W  op tag
dispatch_ready  out  1  controller can accept an op
reg_ready  in  NREGS  per-register operand-available bits
issue_valid  out  1  op offered to GEMM datapath
issue_ready  in  1  datapath accepts
issue_rs1/rs2/rs3, issue_rd  out  REG_W each  held op fields
issue_tag  out  TAG_W  held tag
done_valid  in  1  datapath completion
done_tag  in  TAG_W  tag of completed op
wb_valid  out  1  one-cycle writeback pulse
wb_rd  out  REG_W  writeback destination
wb_tag  out  TAG_W  writeback tag
busy  out  1  op held (to status entry busy field)
flush  in  1  squash held op
err  out  2  sticky: [0] dispatch while busy, [1] EXEC timeout

Behaviour:
- Reset (nRST=1, asynchronous):
  - State returns to IDLE.
  - All held fields, the counter and err clear to 0.
  - All outputs read 0, except dispatch_ready=1.
- State encoding: IDLE, WAIT_OPS, ISSUE, EXEC, DRAIN. busy = (state != IDLE). dispatch_ready = (state == IDLE).
- IDLE:
  - dispatch_en=1 and flush=0 latches rs1/rs2/rs3/rd/tag; next state WAIT_OPS.
  - flush=1 drops a same-cycle dispatch.
- WAIT_OPS:
  - Moves to ISSUE when reg_ready[rs1] & reg_ready[rs2] & reg_ready[rs3], evaluated on the latched indices.
  - A duplicate index only needs its single bit.
- ISSUE:
  - issue_valid=1 and is combinational from state. Fields are stable until the handshake.
  - issue_valid & issue_ready moves to EXEC; the counter is cleared.
- Minimum latency: dispatch in cycle 0, operands ready, issue_valid high in cycle 2.
- EXEC:
  - Counter increments each cycle and saturates at 255.
  - done_valid with done_tag == held tag: wb_valid=1 for exactly that cycle, with wb_rd/wb_tag = held values (combinational); next state IDLE.
  - A mismatched done_tag is ignored.
  - Counter reaching TIMEOUT sets err[1]; the state is unchanged.
- wb_rd/wb_tag read 0 whenever wb_valid=0.
- Flush:
  - WAIT_OPS, or ISSUE without a same-cycle handshake: go to IDLE next cycle, no issue, no wb.
  - ISSUE with a same-cycle handshake, or EXEC: go to DRAIN.
  - EXEC with a matching done in the same cycle: go to IDLE, no wb pulse.
- DRAIN: waits for a matching done, then IDLE with no wb pulse. Further flush has no effect. busy stays 1.
- dispatch_en in any state other than IDLE is ignored and sets err[0].
- err bits clear only on reset.
- issue_ready while issue_valid=0 is ignored.
- No back-to-back overlap: the earliest next dispatch accept is the cycle after the wb pulse.

Test Plan:
- Basic: reset, dispatch rs1=1 rs2=2 rs3=3 rd=4 tag=5 with reg_ready=16'hFFFF, issue_ready=1 -> issue_valid high cycle 2 for 1 cycle; done_valid tag=5 at cycle 6 -> wb_valid=1 wb_rd=4 wb_tag=5 for one cycle, dispatch_ready=1 the following cycle.
- Operand stall: reg_ready=16'h0006, dispatch rs1=1 rs2=2 rs3=3 -> stays WAIT_OPS and issue_valid=0; set bit3 at cycle 10 -> issue_valid=1 at cycle 11.
- Backpressure and tag filter: issue_ready=0 for 4 cycles -> issue_valid and fields held steady; done_tag=6 (held tag=5) -> no wb; done_tag=5 -> wb pulse.
- Flush in each state:
  - WAIT_OPS -> IDLE next cycle, no issue.
  - EXEC -> DRAIN; done_tag match -> IDLE, wb_valid stays 0.
  - Flush coincident with handshake -> DRAIN.
- Errors: dispatch_en while in EXEC -> err=2'b01, held fields unchanged; 255 EXEC cycles without done -> err[1]=1, and a later done still produces wb.
- Async reset mid-EXEC: assert nRST=1 between clock edges -> busy=0, dispatch_ready=1, err=0 immediately; a later done_valid produces no wb.
